// File: rtl/lcd_timing_monitor.sv
// Receive-side geometry/checksum checker for the 480x272 RGB565 LCD bus, oversampled in clk_27mhz.
// Optional pixel checksum accumulator is built only when LCD_MON_CHECKSUM_EN is defined.
module lcd_timing_monitor #(
  parameter int H_ACTIVE    = 480,
  parameter int V_ACTIVE    = 272,
  parameter int LOCK_FRAMES = 4
) (
  input  logic        clk_27mhz,
  input  logic        reset,
  input  logic        lcd_clk_in,
  input  logic        lcd_en_in,
  input  logic        lcd_hsync_in,
  input  logic        lcd_vsync_in,
  input  logic [4:0]  lcd_r_in,
  input  logic [5:0]  lcd_g_in,
  input  logic [4:0]  lcd_b_in,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [8:0]  line_count,
  output logic [9:0]  first_line_len,
  output logic [15:0] frame_checksum,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count,
  output logic        locked
);

  localparam logic [9:0] H_LEN  = H_ACTIVE[9:0];
  localparam logic [8:0] V_LEN  = V_ACTIVE[8:0];
  localparam logic [3:0] LOCK_N = LOCK_FRAMES[3:0];

  typedef enum logic [1:0] {SEEK, FRAME, LINE} state_t;

  // Control bits packed as {clk, en, hsync, vsync}.
  logic [3:0] ctrl_s1, ctrl_s2;
  logic [2:0] hist;  // {clk, en, vsync} one cycle behind ctrl_s2

  logic pix_stb, line_end, frame_end, en_rise;
  logic en_s, hs_s, vs_s;

  assign en_s      = ctrl_s2[2];
  assign hs_s      = ctrl_s2[1];
  assign vs_s      = ctrl_s2[0];
  assign pix_stb   = ctrl_s2[3] & ~hist[2];
  assign en_rise   = en_s & ~hist[1];
  assign line_end  = ~en_s & hist[1];
  assign frame_end = ~vs_s & hist[0];

  state_t     state;
  logic [9:0] px_cnt, first_len;
  logic [8:0] line_cnt;
  logic       geo_err, sync_err;
  logic [3:0] good;

  logic       counting, closing, report, ok_now;
  logic [9:0] px_next, first_next;
  logic [8:0] line_next;
  logic       geo_next, sync_next;
  logic [3:0] good_next;

  // A frame_end arriving mid-line closes that line before the report, in the same cycle,
  // so every "next" value below already includes the closing line.
  always_comb begin
    counting   = (state == LINE) && pix_stb && en_s;
    closing    = (state == LINE) && (line_end || frame_end);
    report     = (state != SEEK) && frame_end;
    px_next    = (counting && px_cnt != 10'h3FF) ? px_cnt + 10'd1 : px_cnt;
    line_next  = (closing && line_cnt != 9'h1FF) ? line_cnt + 9'd1 : line_cnt;
    first_next = (closing && line_cnt == 9'd0) ? px_next : first_len;
    geo_next   = geo_err | (closing && px_next != H_LEN);
    sync_next  = sync_err | ((state != SEEK) && pix_stb && en_s && (!vs_s || !hs_s));
    ok_now     = (line_next == V_LEN) && !geo_next && !sync_next;
    good_next  = !ok_now ? 4'd0 : (good == LOCK_N) ? good : good + 4'd1;
  end

  // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_27mhz) begin
    if (reset) begin
      ctrl_s1        <= '0;
      ctrl_s2        <= '0;
      hist           <= '0;
      state          <= SEEK;
      px_cnt         <= '0;
      line_cnt       <= '0;
      first_len      <= '0;
      geo_err        <= 1'b0;
      sync_err       <= 1'b0;
      good           <= '0;
      frame_done     <= 1'b0;
      frame_ok       <= 1'b0;
      line_count     <= '0;
      first_line_len <= '0;
      frame_count    <= '0;
      err_count      <= '0;
      locked         <= 1'b0;
    end else begin
      ctrl_s1    <= {lcd_clk_in, lcd_en_in, lcd_hsync_in, lcd_vsync_in};
      ctrl_s2    <= ctrl_s1;
      hist       <= {ctrl_s2[3], ctrl_s2[2], ctrl_s2[0]};
      frame_done <= report;
      px_cnt     <= closing ? 10'd0 : px_next;

      unique case (state)
        SEEK:    if (frame_end) state <= FRAME;
        FRAME:   if (!frame_end && en_rise) state <= LINE;
        LINE:    if (line_end || frame_end) state <= FRAME;
        default: state <= SEEK;
      endcase

      if (report) begin
        frame_ok       <= ok_now;
        line_count     <= line_next;
        first_line_len <= first_next;
        frame_count    <= frame_count + 16'd1;
        if (!ok_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
        good           <= good_next;
        locked         <= (good_next == LOCK_N);
        line_cnt       <= '0;
        first_len      <= '0;
        geo_err        <= 1'b0;
        sync_err       <= 1'b0;
      end else begin
        line_cnt       <= line_next;
        first_len      <= first_next;
        geo_err        <= geo_next;
        sync_err       <= sync_next;
      end
    end
  end

`ifdef LCD_MON_CHECKSUM_EN
  logic [15:0] data_s1, data_s2, chk, chk_next;

  assign chk_next = counting ? ({chk[14:0], chk[15]} ^ data_s2) : chk;

  always_ff @(posedge clk_27mhz) begin
    if (reset) begin
      data_s1        <= '0;
      data_s2        <= '0;
      chk            <= '0;
      frame_checksum <= '0;
    end else begin
      data_s1 <= {lcd_r_in, lcd_g_in, lcd_b_in};
      data_s2 <= data_s1;
      if (report) begin
        frame_checksum <= chk_next;
        chk            <= '0;
      end else begin
        chk <= chk_next;
      end
    end
  end
`else
  logic unused_pixel;
  assign unused_pixel   = ^{lcd_r_in, lcd_g_in, lcd_b_in};
  assign frame_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_timing_monitor.sv
// Scoreboard bench for lcd_timing_monitor on a reduced 16x12 geometry, 3 clk_27mhz cycles per pixel.
module tb_lcd_timing_monitor;

  localparam int H = 16;
  localparam int V = 12;
  localparam int LOCKF = 4;

  logic        clk_27mhz = 1'b0;
  logic        reset;
  logic        lcd_clk, lcd_en, lcd_hs, lcd_vs;
  logic [4:0]  lcd_r, lcd_b;
  logic [5:0]  lcd_g;
  logic        frame_done, frame_ok, locked;
  logic [8:0]  line_count;
  logic [9:0]  first_line_len;
  logic [15:0] frame_checksum, frame_count;
  logic [7:0]  err_count;

  lcd_timing_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LOCKF)) dut (
    .clk_27mhz      (clk_27mhz),
    .reset          (reset),
    .lcd_clk_in     (lcd_clk),
    .lcd_en_in      (lcd_en),
    .lcd_hsync_in   (lcd_hs),
    .lcd_vsync_in   (lcd_vs),
    .lcd_r_in       (lcd_r),
    .lcd_g_in       (lcd_g),
    .lcd_b_in       (lcd_b),
    .frame_done     (frame_done),
    .frame_ok       (frame_ok),
    .line_count     (line_count),
    .first_line_len (first_line_len),
    .frame_checksum (frame_checksum),
    .frame_count    (frame_count),
    .err_count      (err_count),
    .locked         (locked)
  );

  always #5 clk_27mhz = ~clk_27mhz;

  int cyc = 0;
  always @(posedge clk_27mhz) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ok;
    int          lines;
    int          first;
    logic [15:0] chk;
    int          fcount;
    int          ecount;
    logic        lock;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   m_frames = 0;
  int   m_errs   = 0;
  int   m_good   = 0;
  int   last_vs_cyc = 0;

`ifdef LCD_MON_CHECKSUM_EN
  localparam logic [15:0] CHK_TWO_PIX = 16'h8002;
`else
  localparam logic [15:0] CHK_TWO_PIX = 16'h0000;
`endif

  // Expected report for the frame about to be sent; counters follow the frame/err/lock rules.
  task automatic push_exp(input logic ok, input int lines, input int first, input logic [15:0] chk);
    exp_t e;
    m_frames = (m_frames + 1) % 65536;
    if (!ok) begin
      if (m_errs < 255) m_errs++;
      m_good = 0;
    end else if (m_good < LOCKF) begin
      m_good++;
    end
    e.ok = ok; e.lines = lines; e.first = first; e.chk = chk;
    e.fcount = m_frames; e.ecount = m_errs; e.lock = (m_good == LOCKF);
    q.push_back(e);
  endtask

  always @(negedge clk_27mhz) begin
    if (!reset && frame_done) begin
      if (q.size() == 0) begin
        check("frame_done_unexpected", frame_done, 0);
      end else begin
        mon_e = q.pop_front();
        check("frame_ok",       frame_ok,       mon_e.ok);
        check("line_count",     line_count,     mon_e.lines);
        check("first_line_len", first_line_len, mon_e.first);
        check("frame_checksum", frame_checksum, mon_e.chk);
        check("frame_count",    frame_count,    mon_e.fcount);
        check("err_count",      err_count,      mon_e.ecount);
        check("locked",         locked,         mon_e.lock);
        check("latency",        cyc - last_vs_cyc, 3);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_ok"},   frame_ok, 0);
    check({tag, "_line_count"}, line_count, 0);
    check({tag, "_first_len"},  first_line_len, 0);
    check({tag, "_checksum"},   frame_checksum, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_err_count"},  err_count, 0);
    check({tag, "_locked"},     locked, 0);
  endtask

  // One pixel slot: data and en change with lcd_clk low, lcd_clk rises for the last cycle.
  task automatic pix(input logic [15:0] p);
    lcd_clk = 1'b0; lcd_en = 1'b1; lcd_hs = 1'b1; {lcd_r, lcd_g, lcd_b} = p;
    @(negedge clk_27mhz); @(negedge clk_27mhz);
    lcd_clk = 1'b1;
    @(negedge clk_27mhz);
  endtask

  task automatic idle(input logic h);
    lcd_clk = 1'b0; lcd_en = 1'b0; lcd_hs = h; {lcd_r, lcd_g, lcd_b} = 16'h0;
    @(negedge clk_27mhz); @(negedge clk_27mhz);
    lcd_clk = 1'b1;
    @(negedge clk_27mhz);
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) pix(16'h0000);
    idle(1'b0); idle(1'b0); idle(1'b1);
  endtask

  task automatic vsync();
    idle(1'b1);
    lcd_vs = 1'b0;
    last_vs_cyc = cyc;
    idle(1'b1); idle(1'b1); idle(1'b1);
    lcd_vs = 1'b1;
    idle(1'b1); idle(1'b1);
  endtask

  task automatic frame(input int nl, input int short_idx, input int short_len);
    for (int l = 0; l < nl; l++) line((l == short_idx) ? short_len : H);
    vsync();
  endtask

  // Last line keeps en high while vsync falls; optionally strobe one pixel while vsync is low.
  task automatic en_into_vsync(input bit strobe);
    for (int l = 0; l < V - 1; l++) line(H);
    for (int i = 0; i < H; i++) pix(16'h0000);
    lcd_clk = 1'b0;
    lcd_vs  = 1'b0;
    last_vs_cyc = cyc;
    repeat (5) @(negedge clk_27mhz);
    if (strobe) begin
      lcd_clk = 1'b1;
      @(negedge clk_27mhz);
      lcd_clk = 1'b0;
    end
    repeat (4) @(negedge clk_27mhz);
    lcd_en = 1'b0;
    repeat (3) @(negedge clk_27mhz);
    lcd_vs = 1'b1;
    idle(1'b1); idle(1'b1);
  endtask

  initial begin
    reset = 1'b1;
    lcd_clk = 1'b0; lcd_en = 1'b0; lcd_hs = 1'b1; lcd_vs = 1'b1;
    {lcd_r, lcd_g, lcd_b} = 16'h0;
    repeat (4) @(negedge clk_27mhz);
    reset = 1'b0;
    check_all_zero("reset");

    vsync();                                        // first vsync only arms the monitor
    for (int f = 0; f < 4; f++) begin
      push_exp(1'b1, V, H, 16'h0000);
      frame(V, -1, 0);
    end

    push_exp(1'b0, V, H, 16'h0000);                 // line 10 one pixel short
    frame(V, 9, H - 1);

    push_exp(1'b0, V - 1, H, 16'h0000);             // one line missing
    frame(V - 1, -1, 0);
    push_exp(1'b1, V, H, 16'h0000);
    frame(V, -1, 0);

    push_exp(1'b0, 1, 2, CHK_TWO_PIX);              // two-pixel checksum frame
    pix(16'h0001);
    pix(16'h8000);
    idle(1'b0); idle(1'b0); idle(1'b1);
    vsync();

    push_exp(1'b1, V, H, 16'h0000);                 // en into vsync, no strobe while low
    en_into_vsync(1'b0);
    push_exp(1'b1, V, H, 16'h0000);                 // strobe while vsync low, after frame_end
    en_into_vsync(1'b1);
    push_exp(1'b0, V, H, 16'h0000);                 // sticky sync error carried into this frame
    frame(V, -1, 0);

    for (int l = 0; l < 5; l++) line(H);            // reset mid-frame
    reset = 1'b1;
    @(negedge clk_27mhz);
    check_all_zero("midreset");
    reset = 1'b0;
    m_frames = 0; m_errs = 0; m_good = 0;
    for (int l = 0; l < 3; l++) line(H);
    vsync();                                        // first vsync after release: no report
    push_exp(1'b1, V, H, 16'h0000);
    frame(V, -1, 0);

    repeat (10) @(negedge clk_27mhz);
    check("pending_reports", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_timing_monitor.md
# lcd_timing_monitor

Receive-side checker for the 480x272 RGB LCD panel interface. It taps the same `lcd_clk`/`lcd_en`/`lcd_hsync`/`lcd_vsync`/RGB565 pins that the panel timing generator drives. It oversamples them in the `clk_27mhz` domain and measures every frame's active geometry and pixel checksum. It reports per-frame pass/fail, error counts and a lock indication for diagnostic top modules and loopback benches.

## Interface
- `H_ACTIVE`, 480: required pixels per active line.
- `V_ACTIVE`, 272: required active lines per frame.
- `LOCK_FRAMES`, 4: consecutive good frames needed to assert `locked`, range 1..15.
- `clk_27mhz` in 1: system clock.
- `reset` in 1: synchronous, active-high; clock `clk_27mhz`.
- `lcd_clk_in` in 1: panel pixel clock, asynchronous to this block.
- `lcd_en_in` in 1: data enable, active-high.
- `lcd_hsync_in` in 1: active-low; monitored only for the sync error.
- `lcd_vsync_in` in 1: active-low.
- `lcd_r_in` in 5, `lcd_g_in` in 6, `lcd_b_in` in 5: pixel data.
- `frame_done` out 1: one-cycle pulse at each frame end.
- `frame_ok` out 1: last frame met geometry with no sync error.
- `line_count` out 9: active lines counted in the last frame.
- `first_line_len` out 10: pixel count of the last frame's first line.
- `frame_checksum` out 16: checksum of the last frame.
- `frame_count` out 16: completed frames, wraps.
- `err_count` out 8: bad frames, saturates at 255.
- `locked` out 1: LOCK_FRAMES consecutive good frames seen.

## Operation
- All inputs pass through a 2-flop synchronizer, then a 1-flop history stage.
- Edge events, all derived from the synchronized signals:
  - pix_stb: rising edge of the synchronized `lcd_clk_in`.
  - line_end: `lcd_en` 1->0.
  - frame_end: `lcd_vsync` 1->0.
- Pixel data is taken from the synchronizer stage in the same cycle as pix_stb.
- Source levels must each hold at least 1 `clk_27mhz` cycle. For a 9 MHz `lcd_clk`, every level is seen at least once.
- FSM states:
  - SEEK: entered on reset. Ignores everything except frame_end, which moves to FRAME without reporting.
  - FRAME: between lines. `lcd_en` 0->1 moves to LINE. frame_end reports the frame and stays in FRAME.
  - LINE: on pix_stb, px_cnt increments (10-bit, saturates at 1023) and the checksum updates. line_end closes the line and returns to FRAME. frame_end while in LINE closes the line first and then reports, in the same cycle.
- Line close:
  - line_cnt increments (9-bit, saturates at 511).
  - The first line of a frame stores its px_cnt into a shadow first_len.
  - Any line with px_cnt != H_ACTIVE sets a sticky geo_err.
  - px_cnt then clears.
- Sync error: a pix_stb with en=1 while vsync=0 or hsync=0 sets a sticky sync_err.
- Frame report, on frame_end:
  - Latch `line_count`, `first_line_len` and `frame_checksum`.
  - `frame_ok` = (line_cnt == V_ACTIVE) and !geo_err and !sync_err.
  - Pulse `frame_done`. Increment `frame_count`. If the frame is not ok, increment `err_count` with saturation.
  - Clear line_cnt, the checksum accumulator, geo_err and sync_err.
- Checksum: on each counted pixel, p = {r,g,b} (RGB565) and chk <= {chk[14:0], chk[15]} ^ p. The accumulator resets to 0x0000 at each frame start.
- Lock:
  - A 4-bit good counter increments on each ok frame, saturating at LOCK_FRAMES.
  - `locked` = (good == LOCK_FRAMES).
  - A bad frame clears good and deasserts `locked` in the same cycle `frame_done` pulses.
- Reset value of every output is 0. Reset mid-frame returns the FSM to SEEK, so the partial frame is never reported.

## Timing
- Latency: `frame_done`, all latched outputs and `locked` update 3 `clk_27mhz` edges after the first edge that samples `lcd_vsync_in` low.
- `frame_done` is high exactly 1 cycle per frame_end.
- Latched outputs are stable until the next `frame_done`.
- A simultaneous line_end and frame_end is handled as close-line-then-report in one cycle; the closed line counts toward the reported frame.
- A pix_stb in the line_end cycle is counted only if the synchronized en is still 1 in that cycle.

## Configuration
- `LCD_MON_CHECKSUM_EN` defined: the checksum accumulator and `frame_checksum` are built as described.
- Not defined: no accumulator logic; `frame_checksum` is constant 0. Geometry checking is unaffected.

## Test plan
- Nominal 480x272 frames with a 9 MHz lcd_clk (3 cycles/pixel) and all-zero pixels, after reset:
  - The first vsync gives no `frame_done`.
  - The next 4 frames each give frame_ok=1, line_count=272, first_line_len=480, checksum 0x0000.
  - `locked`=1 on the 4th reported frame.
- One frame whose line 10 has 479 pixels -> frame_ok=0, err_count=1, `locked` drops in the same cycle, first_line_len=480.
- A frame with 271 lines -> frame_ok=0, line_count=271. The following good frame -> frame_ok=1, err_count unchanged.
- A single line with pixel values 0x0001 then 0x8000 (`LCD_MON_CHECKSUM_EN` defined), then vsync -> frame_checksum=0x8002.
- `lcd_en` held high into the vsync assertion at pixel 480 of the last line -> line closed, line_count=272, sync_err only if a pixel is strobed while vsync is low. Verify both cases.
- Reset asserted mid-frame (line 100) -> all outputs 0 next cycle; no `frame_done` until the second vsync after reset release.
